pc_next_unit: RTL and testbench

- Program-counter register and next-PC selector for the datapath.
- Sits directly downstream of the branch-offset shift-left-by-2 stage. Its sl_offset input is that stage's 32-bit output, the sign-extended immediate shifted left by 2.
- Computes sequential, branch, jump, jump-register, exception and return targets, and holds the PC.
- Presents the PC to instruction fetch through a valid/ready handshake.

---
 rtl/pc_next_unit.sv | 111 +++++++++++
 tb/tb_pc_next_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Program counter with next-PC selection (sequential, branch, jump, jr, exception, eret).
// Latency: selected target appears on pc one clk after the advancing edge; pc_plus4 is combinational.
// Backpressure: pc holds while fetch_ready is low or stall is high; exc still preempts in RUN.
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] sl_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect,
    output logic [31:0] epc,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] epc_nxt;
    logic        redirect_nxt;
    logic        addr_err_nxt;
    logic        advance;
    logic [31:0] btgt;
    logic [31:0] jtgt;

    assign pc_plus4    = pc + 32'd4;
    assign btgt        = pc_plus4 + sl_offset;
    assign jtgt        = {pc_plus4[31:28], jump_index, 2'b00};
    assign fetch_valid = (state == RUN);
    assign advance     = fetch_valid & fetch_ready & ~stall;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        epc_nxt      = epc;
        redirect_nxt = 1'b0;
        addr_err_nxt = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            TRAP: state_nxt = RUN;
            RUN: begin
                // exc overrides the handshake; everything else waits for advance
                if (exc) begin
                    epc_nxt      = pc;
                    pc_nxt       = EXC_VECTOR;
                    redirect_nxt = 1'b1;
                    state_nxt    = TRAP;
                end else if (advance) begin
                    if (eret) begin
                        pc_nxt       = epc;
                        redirect_nxt = 1'b1;
                    end else if (jr) begin
                        redirect_nxt = 1'b1;
                        if (jr_target[1:0] != 2'b00) begin
                            epc_nxt      = pc;
                            pc_nxt       = EXC_VECTOR;
                            addr_err_nxt = 1'b1;
                            state_nxt    = TRAP;
                        end else begin
                            pc_nxt = jr_target;
                        end
                    end else if (jump) begin
                        pc_nxt       = jtgt;
                        redirect_nxt = 1'b1;
                    end else if (branch && zero) begin
                        pc_nxt       = btgt;
                        redirect_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            epc      <= 32'h0000_0000;
            redirect <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            epc      <= epc_nxt;
            redirect <= redirect_nxt;
            addr_err <= addr_err_nxt;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomised and directed bench for pc_next_unit against a cycle-level behavioural model.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        branch;
    logic        zero;
    logic [31:0] sl_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect;
    logic [31:0] epc;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    // model: mode 0 = booting, 1 = running, 2 = one-cycle trap bubble
    int          m_mode;
    logic [31:0] m_pc, m_epc;
    logic        m_red, m_ae;

    localparam logic [31:0] EXC_ADDR = 32'h0000_0180;

    pc_next_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
        .branch(branch), .zero(zero), .sl_offset(sl_offset), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_target(jr_target), .exc(exc),
        .eret(eret), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .redirect(redirect), .epc(epc), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_epc = 32'h0; m_red = 1'b0; m_ae = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] npc;
        m_red = 1'b0;
        m_ae  = 1'b0;
        if (m_mode != 1) begin
            m_mode = 1;
        end else if (exc) begin
            m_epc = m_pc; m_pc = EXC_ADDR; m_red = 1'b1; m_mode = 2;
        end else if (fetch_ready && !stall) begin
            npc = m_pc + 32'd4;
            if (eret) begin
                m_pc = m_epc; m_red = 1'b1;
            end else if (jr && (jr_target % 4 != 0)) begin
                m_epc = m_pc; m_pc = EXC_ADDR; m_red = 1'b1; m_ae = 1'b1; m_mode = 2;
            end else if (jr) begin
                m_pc = jr_target; m_red = 1'b1;
            end else if (jump) begin
                m_pc = (npc & 32'hF000_0000) + ({6'd0, jump_index} * 4); m_red = 1'b1;
            end else if (branch && zero) begin
                m_pc = npc + sl_offset; m_red = 1'b1;
            end else begin
                m_pc = npc;
            end
        end
    endtask

    task automatic clear_inputs();
        stall = 0; fetch_ready = 1; branch = 0; zero = 0; sl_offset = 0;
        jump = 0; jump_index = 0; jr = 0; jr_target = 0; exc = 0; eret = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] tgt);
        clear_inputs();
        jr = 1; jr_target = tgt;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        #12;
        checks++; if (pc !== 32'h0 || epc !== 32'h0) begin errors++; $display("FAIL reset_pc_epc: got pc=%h epc=%h want 0 0", pc, epc); end
        checks++; if ({fetch_valid, redirect, addr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {fetch_valid, redirect, addr_err}); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", fetch_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i] || fetch_valid !== 1'b1 || redirect !== 1'b0) begin
                errors++; $display("FAIL seq_%0d: got pc=%h fv=%b red=%b want pc=%h fv=1 red=0", i, pc, fetch_valid, redirect, exp_pc[i]);
            end
            if (i < 3) begin
                checks++; if (pc_plus4 !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL seq_plus4_%0d: got %h want %h", i, pc_plus4, exp_pc[i] + 32'd4); end
            end
        end
    endtask

    task automatic test_branch();
        set_pc(32'h100);
        branch = 1; zero = 1; sl_offset = 32'hFFFF_FFF0;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'hF4 || redirect !== 1'b1) begin errors++; $display("FAIL branch_taken: got pc=%h red=%b want pc=000000f4 red=1", pc, redirect); end
        tick();
        checks++; if (pc !== 32'hF8 || redirect !== 1'b0) begin errors++; $display("FAIL branch_pulse_end: got pc=%h red=%b want pc=000000f8 red=0", pc, redirect); end
        set_pc(32'h100);
        branch = 1; zero = 0; sl_offset = 32'hFFFF_FFF0;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h104 || redirect !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got pc=%h red=%b want pc=00000104 red=0", pc, redirect); end
    endtask

    task automatic test_jump();
        set_pc(32'h1000_0040);
        jump = 1; jump_index = 26'h123;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h1000_048C || redirect !== 1'b1) begin errors++; $display("FAIL jump: got pc=%h red=%b want pc=1000048c red=1", pc, redirect); end
        set_pc(32'h1000_0040);
        jump = 1; jump_index = 26'h123; branch = 1; zero = 1; sl_offset = 32'h40;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h1000_048C) begin errors++; $display("FAIL jump_over_branch: got %h want 1000048c", pc); end
    endtask

    task automatic test_stall();
        set_pc(32'h20);
        for (int i = 0; i < 6; i++) begin
            jump = 1; jump_index = 26'h3FF;
            stall = (i < 3); fetch_ready = (i >= 3) ? 1'b0 : 1'b1;
            tick();
            checks++; if (pc !== 32'h20 || redirect !== (i == 0 ? 1'b0 : 1'b0)) begin
                errors++; $display("FAIL hold_%0d: got pc=%h red=%b want pc=00000020 red=0", i, pc, redirect);
            end
        end
        clear_inputs();
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL hold_release: got %h want 00000024", pc); end
    endtask

    task automatic test_exc_eret();
        set_pc(32'h200);
        stall = 1; exc = 1;
        tick();
        clear_inputs();
        checks++; if (epc !== 32'h200 || pc !== EXC_ADDR || fetch_valid !== 1'b0 || redirect !== 1'b1) begin
            errors++; $display("FAIL exc_entry: got epc=%h pc=%h fv=%b red=%b want 00000200 00000180 0 1", epc, pc, fetch_valid, redirect);
        end
        tick();
        checks++; if (fetch_valid !== 1'b1 || pc !== EXC_ADDR || redirect !== 1'b0) begin
            errors++; $display("FAIL trap_exit: got fv=%b pc=%h red=%b want 1 00000180 0", fetch_valid, pc, redirect);
        end
        tick();
        eret = 1;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h200 || redirect !== 1'b1) begin errors++; $display("FAIL eret: got pc=%h red=%b want 00000200 1", pc, redirect); end
        set_pc(32'h300);
        exc = 1; eret = 1;
        tick();
        clear_inputs();
        checks++; if (pc !== EXC_ADDR || epc !== 32'h300) begin errors++; $display("FAIL exc_over_eret: got pc=%h epc=%h want 00000180 00000300", pc, epc); end
        tick();
    endtask

    task automatic test_jr_misaligned();
        set_pc(32'h40);
        jr = 1; jr_target = 32'h0000_3002;
        tick();
        clear_inputs();
        checks++; if (addr_err !== 1'b1 || redirect !== 1'b1 || pc !== EXC_ADDR || epc !== 32'h40 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL jr_misaligned: got ae=%b red=%b pc=%h epc=%h fv=%b want 1 1 00000180 00000040 0", addr_err, redirect, pc, epc, fetch_valid);
        end
        tick();
        checks++; if (addr_err !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL jr_pulse_end: got ae=%b red=%b want 0 0", addr_err, redirect); end
    endtask

    task automatic test_reset_mid();
        set_pc(32'h500);
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL pre_reset_redirect: got %b want 1", redirect); end
        #1;
        rst_n = 0;
        model_reset();
        #1;
        checks++; if (pc !== 32'h0 || epc !== 32'h0 || {fetch_valid, redirect, addr_err} !== 3'b000) begin
            errors++; $display("FAIL mid_reset: got pc=%h epc=%h flags=%b want 0 0 000", pc, epc, {fetch_valid, redirect, addr_err});
        end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
        tick();
        checks++; if (pc !== 32'h0 || redirect !== 1'b0) begin errors++; $display("FAIL wrap_pc: got pc=%h red=%b want 0 0", pc, redirect); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            branch      = $urandom_range(0, 1);
            zero        = $urandom_range(0, 1);
            sl_offset   = $urandom & 32'hFFFF_FFFC;
            jump        = ($urandom_range(0, 4) == 0);
            jump_index  = 26'($urandom);
            jr          = ($urandom_range(0, 5) == 0);
            jr_target   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            exc         = ($urandom_range(0, 15) == 0);
            eret        = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (pc !== m_pc || epc !== m_epc || redirect !== m_red || addr_err !== m_ae ||
                fetch_valid !== (m_mode == 1) || pc_plus4 !== m_pc + 32'd4) begin
                errors++;
                $display("FAIL random_%0d: got pc=%h epc=%h red=%b ae=%b fv=%b p4=%h want pc=%h epc=%h red=%b ae=%b fv=%b p4=%h",
                         i, pc, epc, redirect, addr_err, fetch_valid, pc_plus4,
                         m_pc, m_epc, m_red, m_ae, (m_mode == 1), m_pc + 32'd4);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_exc_eret();
        test_jr_misaligned();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
